// File: rtl/axi_arbiter_w.sv
// Round-robin write-channel arbiter for four AXI masters sharing one slave write path.
// Holds each grant from address phase through the write response and flags WLAST/AWLEN mismatches.
module axi_arbiter_w (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       m0_AWVALID,
  input  logic       m1_AWVALID,
  input  logic       m2_AWVALID,
  input  logic       m3_AWVALID,
  input  logic       s_AWVALID,
  input  logic       m_AWREADY,
  input  logic [7:0] s_AWLEN,
  input  logic       s_WVALID,
  input  logic       m_WREADY,
  input  logic       s_WLAST,
  input  logic       m_BVALID,
  input  logic       s_BREADY,
  output logic       m0_wgrnt,
  output logic       m1_wgrnt,
  output logic       m2_wgrnt,
  output logic       m3_wgrnt,
  output logic [1:0] wowner,
  output logic       wbusy,
  output logic       burst_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  grant;
  logic [3:0]  grant_nxt;
  logic [1:0]  owner_nxt;
  logic [7:0]  len_q;
  logic [7:0]  len_nxt;
  logic [7:0]  beat_cnt;
  logic [7:0]  beat_nxt;
  logic [7:0]  beat_inc;
  logic        wlast_seen;
  logic        wlast_nxt;
  logic [8:0]  total_q;
  logic [8:0]  total_nxt;
  logic [8:0]  beat_total;
  logic        complete;
  logic [8:0]  cmp_total;
  logic [7:0]  cmp_len;
  logic        err_nxt;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;
  logic [3:0]  req;
  logic        found;
  logic [1:0]  winner;
  logic [1:0]  cand;

  assign aw_hs = s_AWVALID & m_AWREADY;
  assign w_hs  = s_WVALID & m_WREADY;
  assign b_hs  = m_BVALID & s_BREADY;
  assign req   = {m3_AWVALID, m2_AWVALID, m1_AWVALID, m0_AWVALID};

  // Search starts just above the previous owner and wraps, so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = wowner;
    cand   = wowner;
    for (int k = 0; k < 4; k++) begin
      cand = wowner + 2'd1 + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // The WLAST beat is added on top of the saturated count so a 256-beat burst totals 256.
  assign beat_inc   = (beat_cnt == 8'hFF) ? beat_cnt : beat_cnt + 8'd1;
  assign beat_total = {1'b0, beat_cnt} + 9'd1;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    owner_nxt = wowner;
    len_nxt   = len_q;
    beat_nxt  = beat_cnt;
    wlast_nxt = wlast_seen;
    total_nxt = total_q;
    complete  = 1'b0;
    cmp_total = total_q;
    cmp_len   = len_q;

    case (state)
      IDLE: begin
        beat_nxt  = 8'd0;
        wlast_nxt = 1'b0;
        total_nxt = 9'd0;
        if (found) begin
          grant_nxt = 4'b0001 << winner;
          owner_nxt = winner;
          state_nxt = ADDR;
        end
      end

      ADDR: begin
        if (w_hs) begin
          beat_nxt = beat_inc;
          if (s_WLAST && !wlast_seen) begin
            wlast_nxt = 1'b1;
            total_nxt = beat_total;
          end
        end
        // W data may arrive ahead of the address, so completion can happen right here.
        if (aw_hs) begin
          len_nxt = s_AWLEN;
          if (wlast_seen) begin
            complete  = 1'b1;
            cmp_total = total_q;
            cmp_len   = s_AWLEN;
            state_nxt = RESP;
          end else if (w_hs && s_WLAST) begin
            complete  = 1'b1;
            cmp_total = beat_total;
            cmp_len   = s_AWLEN;
            state_nxt = RESP;
          end else begin
            state_nxt = DATA;
          end
        end
      end

      DATA: begin
        if (w_hs) begin
          beat_nxt = beat_inc;
          if (s_WLAST) begin
            wlast_nxt = 1'b1;
            total_nxt = beat_total;
            complete  = 1'b1;
            cmp_total = beat_total;
            cmp_len   = len_q;
            state_nxt = RESP;
          end
        end
      end

      RESP: begin
        if (b_hs) begin
          grant_nxt = 4'b0000;
          beat_nxt  = 8'd0;
          wlast_nxt = 1'b0;
          total_nxt = 9'd0;
          state_nxt = IDLE;
        end
      end

      default: begin
        grant_nxt = 4'b0000;
        state_nxt = IDLE;
      end
    endcase

    err_nxt = complete && (cmp_total != ({1'b0, cmp_len} + 9'd1));
  end

  // Reset parks wowner at 3 so master 0 is first in line afterwards.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      grant      <= 4'b0000;
      wowner     <= 2'd3;
      len_q      <= 8'd0;
      beat_cnt   <= 8'd0;
      wlast_seen <= 1'b0;
      total_q    <= 9'd0;
      burst_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      wowner     <= owner_nxt;
      len_q      <= len_nxt;
      beat_cnt   <= beat_nxt;
      wlast_seen <= wlast_nxt;
      total_q    <= total_nxt;
      burst_err  <= err_nxt;
    end
  end

  assign m0_wgrnt = grant[0];
  assign m1_wgrnt = grant[1];
  assign m2_wgrnt = grant[2];
  assign m3_wgrnt = grant[3];
  assign wbusy    = |grant;

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Self-checking bench for axi_arbiter_w: transaction-level round-robin model with
// randomized masks, burst lengths, W/AW ordering and handshake stalls.
module tb_axi_arbiter_w;

  logic       clk = 1'b0;
  logic       areset;
  logic [3:0] awv;
  logic       s_awvalid;
  logic       m_awready;
  logic [7:0] s_awlen;
  logic       s_wvalid;
  logic       m_wready;
  logic       s_wlast;
  logic       m_bvalid;
  logic       s_bready;
  logic [3:0] grnt;
  logic [1:0] wowner;
  logic       wbusy;
  logic       burst_err;

  int vectors = 0;
  int errors = 0;
  int model_owner = 3;

  typedef struct {
    bit aw;
    bit awstall;
    bit w;
    bit wstall;
    bit wlast;
    bit bv;
    bit br;
    bit done;
  } cyc_t;

  always #5 clk = ~clk;

  axi_arbiter_w dut (
    .ACLK       (clk),
    .ARESET     (areset),
    .m0_AWVALID (awv[0]),
    .m1_AWVALID (awv[1]),
    .m2_AWVALID (awv[2]),
    .m3_AWVALID (awv[3]),
    .s_AWVALID  (s_awvalid),
    .m_AWREADY  (m_awready),
    .s_AWLEN    (s_awlen),
    .s_WVALID   (s_wvalid),
    .m_WREADY   (m_wready),
    .s_WLAST    (s_wlast),
    .m_BVALID   (m_bvalid),
    .s_BREADY   (s_bready),
    .m0_wgrnt   (grnt[0]),
    .m1_wgrnt   (grnt[1]),
    .m2_wgrnt   (grnt[2]),
    .m3_wgrnt   (grnt[3]),
    .wowner     (wowner),
    .wbusy      (wbusy),
    .burst_err  (burst_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus;
    s_awvalid = 1'b0;
    m_awready = 1'b0;
    s_wvalid  = 1'b0;
    m_wready  = 1'b0;
    s_wlast   = 1'b0;
    m_bvalid  = 1'b0;
    s_bready  = 1'b0;
  endtask

  // One full write transaction: grant, AW/W in the requested order, response, release.
  // mode 0: AW before data, 1: all data (incl. WLAST) before AW, 2: AW together with WLAST.
  task automatic run_txn(input logic [3:0] mask, input logic [3:0] noise, input int awlen,
                         input int nbeats, input int mode, input int bdelay, input string tag);
    cyc_t plan[$];
    cyc_t c;
    int win;
    bit exp_err;
    bit rel;
    logic [3:0] exp_g;
    logic exp_be;
    win = -1;
    for (int k = 1; k <= 4; k++)
      if (win < 0 && mask[(model_owner + k) % 4]) win = (model_owner + k) % 4;
    exp_err = (nbeats != awlen + 1);

    clear_bus();
    s_awlen = 8'(awlen);
    awv = mask;
    tick();
    exp_g = 4'b0001 << win;
    vectors++;
    if (grnt !== exp_g || wowner !== 2'(win) || wbusy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s grant: got grnt=%b wowner=%0d wbusy=%b, want grnt=%b wowner=%0d wbusy=1",
               tag, grnt, wowner, wbusy, exp_g, win);
    end
    awv = noise;

    if (mode == 0) begin
      if ($urandom_range(0, 1) == 1) begin
        c = '{default: 0};
        c.aw = 1; c.awstall = 1;
        plan.push_back(c);
      end
      c = '{default: 0};
      c.aw = 1;
      plan.push_back(c);
    end
    for (int i = 1; i <= nbeats; i++) begin
      bit last;
      last = (i == nbeats);
      if ($urandom_range(0, 3) == 0) begin
        c = '{default: 0};
        c.w = 1; c.wstall = 1; c.wlast = last;
        plan.push_back(c);
      end
      c = '{default: 0};
      c.w = 1; c.wlast = last;
      if (last && mode == 0) c.done = 1;
      if (last && mode == 2) begin c.aw = 1; c.done = 1; end
      plan.push_back(c);
    end
    if (mode == 1) begin
      c = '{default: 0};
      c.aw = 1; c.done = 1;
      plan.push_back(c);
    end
    for (int i = 0; i < bdelay; i++) begin
      c = '{default: 0};
      c.bv = 1'($urandom_range(0, 1));
      c.br = !c.bv;
      plan.push_back(c);
    end
    c = '{default: 0};
    c.bv = 1; c.br = 1;
    plan.push_back(c);

    foreach (plan[i]) begin
      s_awvalid = plan[i].aw;
      m_awready = plan[i].aw && !plan[i].awstall;
      s_wvalid  = plan[i].w;
      m_wready  = plan[i].w && !plan[i].wstall;
      s_wlast   = plan[i].wlast;
      m_bvalid  = plan[i].bv;
      s_bready  = plan[i].br;
      tick();
      rel    = plan[i].bv && plan[i].br;
      exp_g  = rel ? 4'b0000 : (4'b0001 << win);
      exp_be = plan[i].done && exp_err;
      vectors++;
      if (grnt !== exp_g || wbusy !== !rel || wowner !== 2'(win) || burst_err !== exp_be) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got grnt=%b wbusy=%b wowner=%0d berr=%b, want grnt=%b wbusy=%b wowner=%0d berr=%b",
                 tag, i, grnt, wbusy, wowner, burst_err, exp_g, !rel, win, exp_be);
      end
    end
    clear_bus();
    awv = 4'b0000;
    model_owner = win;
  endtask

  task automatic test_reset;
    clear_bus();
    s_awlen = 8'd0;
    awv = 4'hF;
    areset = 1'b1;
    tick();
    tick();
    vectors++;
    if (grnt !== 4'b0000 || wowner !== 2'd3 || wbusy !== 1'b0 || burst_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: got grnt=%b wowner=%0d wbusy=%b berr=%b, want 0000/3/0/0",
               grnt, wowner, wbusy, burst_err);
    end
    awv = 4'b0000;
    areset = 1'b0;
    model_owner = 3;
  endtask

  task automatic test_idle_quiet;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (grnt !== 4'b0000 || wbusy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_quiet: got grnt=%b wbusy=%b, want 0000/0", grnt, wbusy);
      end
    end
  endtask

  task automatic test_round_robin_all;
    for (int i = 0; i < 5; i++) run_txn(4'hF, 4'hF, 0, 1, 0, 0, "rr_all");
  endtask

  task automatic test_m2_burst;
    run_txn(4'b0100, 4'b0000, 3, 4, 0, 2, "m2_burst");
  endtask

  task automatic test_w_before_aw;
    run_txn(4'b0010, 4'b0000, 0, 1, 1, 1, "w_first");
    run_txn(4'b1000, 4'b0000, 2, 3, 1, 0, "w_first_multi");
    run_txn(4'b0001, 4'b0000, 1, 2, 2, 1, "aw_with_last");
  endtask

  task automatic test_short_burst;
    run_txn(4'b0010, 4'b0000, 3, 2, 0, 1, "short_burst");
    run_txn(4'b0100, 4'b0000, 1, 4, 0, 0, "long_burst_err");
  endtask

  task automatic test_hold_and_wrap;
    run_txn(4'b0100, 4'b0000, 1, 2, 0, 0, "hold_setup");
    run_txn(4'b1011, 4'b0011, 2, 3, 0, 3, "hold_m3");
    run_txn(4'b0011, 4'b0000, 0, 1, 0, 0, "wrap_m0");
  endtask

  task automatic test_max_burst;
    run_txn(4'b0001, 4'b0000, 255, 256, 0, 1, "max_256");
    run_txn(4'b0010, 4'b0000, 255, 256, 1, 0, "max_256_wfirst");
  endtask

  task automatic test_reset_midburst;
    logic [3:0] exp_g;
    int win;
    win = -1;
    for (int k = 1; k <= 4; k++)
      if (win < 0 && k == 1) win = (model_owner + 1) % 4;
    exp_g = 4'b0001 << win;
    clear_bus();
    awv = 4'b0001 << win;
    tick();
    awv = 4'b0000;
    s_awlen = 8'd7;
    s_awvalid = 1'b1; m_awready = 1'b1;
    tick();
    clear_bus();
    s_wvalid = 1'b1; m_wready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (grnt !== exp_g || wbusy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_burst_hold: got grnt=%b wbusy=%b, want %b/1", grnt, wbusy, exp_g);
    end
    areset = 1'b1;
    tick();
    areset = 1'b0;
    clear_bus();
    vectors++;
    if (grnt !== 4'b0000 || wbusy !== 1'b0 || wowner !== 2'd3 || burst_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_burst_reset: got grnt=%b wbusy=%b wowner=%0d berr=%b, want 0000/0/3/0",
               grnt, wbusy, wowner, burst_err);
    end
    model_owner = 3;
  endtask

  task automatic test_reset_pending_err;
    clear_bus();
    awv = 4'b0001;
    tick();
    awv = 4'b0000;
    s_awlen = 8'd3;
    s_awvalid = 1'b1; m_awready = 1'b1;
    tick();
    clear_bus();
    s_wvalid = 1'b1; m_wready = 1'b1; s_wlast = 1'b1;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    clear_bus();
    vectors++;
    if (burst_err !== 1'b0 || grnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_pending_err: got berr=%b grnt=%b, want 0/0000", burst_err, grnt);
    end
    tick();
    vectors++;
    if (burst_err !== 1'b0 || wbusy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pending_err_after: got berr=%b wbusy=%b, want 0/0", burst_err, wbusy);
    end
    model_owner = 3;
    run_txn(4'hF, 4'h0, 0, 1, 0, 0, "after_reset_m0");
  endtask

  task automatic test_random;
    logic [3:0] mask;
    int awlen;
    int nbeats;
    for (int t = 0; t < 40; t++) begin
      mask = 4'($urandom_range(1, 15));
      awlen = $urandom_range(0, 7);
      nbeats = ($urandom_range(0, 1) == 1) ? awlen + 1 : $urandom_range(1, 9);
      run_txn(mask, 4'($urandom), awlen, nbeats, $urandom_range(0, 2), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    areset = 1'b1;
    awv = 4'b0000;
    s_awlen = 8'd0;
    clear_bus();
    test_reset();
    test_idle_quiet();
    test_round_robin_all();
    test_m2_burst();
    test_w_before_aw();
    test_short_burst();
    test_hold_and_wrap();
    test_max_burst();
    test_reset_midburst();
    test_reset_pending_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axi_arbiter_w.md
AXI_ARBITER_W -- requirements
Module: axi_arbiter_w

Interface
REQ-001 Parameters: none; the block serves 4 write masters and 1 shared slave-side write path, with AWLEN fixed at 8 bits.
REQ-002 ACLK  in  1  clock; all logic on rising edge.
REQ-003 ARESET  in  1  reset, synchronous, active-high.
REQ-004 m0_AWVALID..m3_AWVALID  in  1 each  per-master write-address request.
REQ-005 s_AWVALID, m_AWREADY  in  1 each  muxed AW handshake of granted master/slave.
REQ-006 s_AWLEN  in  8  muxed burst length of granted master.
REQ-007 s_WVALID, m_WREADY, s_WLAST  in  1 each  muxed W handshake and last flag.
REQ-008 m_BVALID, s_BREADY  in  1 each  muxed B handshake.
REQ-009 m0_wgrnt..m3_wgrnt  out  1 each  registered one-hot write grant to the write mux.
REQ-010 wowner  out  2  index of current/last owner.
REQ-011 wbusy  out  1  high while any grant is asserted.
REQ-012 burst_err  out  1  one-cycle pulse on WLAST/AWLEN beat-count mismatch.

Function
REQ-013 An AW handshake (aw_hs) is s_AWVALID&m_AWREADY, a W beat (w_hs) is s_WVALID&m_WREADY, and a B handshake (b_hs) is m_BVALID&s_BREADY.
REQ-014 FSM states are IDLE, ADDR, DATA and RESP, with all grants 0 in IDLE and exactly one grant at 1 in every other state.
REQ-015 IDLE, when any mx_AWVALID is 1: select a winner, register its grant, store its index in wowner, and go to ADDR, so the grant appears 1 cycle after AWVALID is sampled.
REQ-016 Round-robin arbitration: the search starts at index (wowner+1) mod 4, continues upward with wrap, and the first requester found wins.
REQ-017 ADDR: on aw_hs, capture s_AWLEN into len_q and go to DATA, or go directly to RESP if the WLAST beat has already completed (before or in the same cycle).
REQ-018 The block accepts W beats in ADDR as well as in DATA (W-before-AW is legal); every w_hs increments the 8-bit beat counter, which saturates at 255.
REQ-019 DATA: on w_hs with s_WLAST=1, go to RESP.
REQ-020 RESP: on b_hs, clear the grant and go to IDLE, so there is a minimum 1 idle cycle between owners.
REQ-021 The grant is never revoked or changed before b_hs, and no timeout exists.
REQ-022 Burst completion is the cycle in which both the AW capture and the WLAST beat have occurred; the WLAST beat counts toward the total.
REQ-023 At completion, burst_err pulses for 1 cycle (registered, visible the next cycle) if total beats != len_q+1; if len_q+1 = 256 the compare uses saturated count 255 plus the WLAST beat.
REQ-024 The beat counter and the WLAST-seen flag clear on entry to IDLE.
REQ-025 A requester that drops AWVALID before being granted loses its turn with no side effect; arbitration uses only the sampled cycle.
REQ-026 Requests from non-owners are ignored outside IDLE.
REQ-027 wbusy = OR of the grants; wowner holds its value after the grant drops.

Reset
REQ-028 On ARESET=1 at a clock edge, the block SHALL set: state IDLE, all grants 0, wbusy 0, burst_err 0, beat counter 0, len_q 0, WLAST-seen 0, and wowner 3 (so m0 has first priority).
REQ-029 Reset during ADDR, DATA or RESP SHALL abort the transfer immediately, with grants low on the cycle after the reset edge; no pending burst_err is emitted.
REQ-030 ARESET dominates all other inputs in the same cycle.

Verification
REQ-031 After reset, m0..m3 AWVALID all 1 in the same cycle -> m0_wgrnt=1 next cycle, then owners m1, m2, m3, m0 on successive transactions, each separated by 1 idle cycle.
REQ-032 m2 only, AWLEN=3, aw_hs cycle 2, 4 W beats with WLAST on 4th, b_hs 2 cycles later -> m2_wgrnt high from cycle 1 until the cycle after b_hs, burst_err stays 0.
REQ-033 W-before-AW: m1, AWLEN=0, WLAST beat occurs one cycle before aw_hs -> FSM goes ADDR->RESP directly, burst_err 0.
REQ-034 AWLEN=3 but WLAST on beat 2 -> burst_err=1 for exactly 1 cycle after completion, FSM still reaches RESP and releases on b_hs.
REQ-035 AWLEN=255, 256 beats -> no burst_err; then ARESET asserted in DATA mid-burst of the next transfer -> grants 0 next cycle and wowner=3.
REQ-036 m3 owns, m0 and m1 request throughout the transfer -> grants unchanged until b_hs, next owner m0 (wrap from 3).
